// File: rtl/rs_alloc_scheduler.sv
// rs_alloc_scheduler
//
// Reservation-station entry allocator and in-order dispatch scheduler.
// Each cycle the heads of DISP_WIDTH dispatch queues are granted in program
// order (slot 0 oldest) into free RS entries. Each granted slot takes the next
// lowest-numbered free entry. Entries are reclaimed when issue reports them
// freed, and all entries are reclaimed on a pipeline flush.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-low reset
//   disp_valid  in   [DISP_WIDTH]      per-slot dispatch queue head valid
//   disp_stall  in   backend stall, suppresses all grants
//   flush       in   pipeline flush, frees every entry
//   free_valid  in   [ISSUE_WIDTH]     per-port entry release valid
//   free_idx    in   [ISSUE_WIDTH*IDXW] packed released entry indices
//   disp_grant  out  [DISP_WIDTH]      per-slot grant, used as queue r_en
//   alloc_idx   out  [DISP_WIDTH*IDXW] packed allocated index, zero if no grant
//   free_count  out  [IDXW+1]          registered number of free entries
//   rs_full     out  registered, high when free_count is zero
//
// disp_grant and alloc_idx are combinational, so a queue pops in the same
// cycle its uop is accepted. They depend only on registered state and the
// dispatch/flush/stall/reset inputs, never on free_valid/free_idx.

module rs_alloc_scheduler #(
  parameter int DISP_WIDTH  = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int RS_ENTRIES  = 16,
  parameter int IDXW        = $clog2(RS_ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DISP_WIDTH-1:0]       disp_valid,
  input  logic                        disp_stall,
  input  logic                        flush,
  input  logic [ISSUE_WIDTH-1:0]      free_valid,
  input  logic [ISSUE_WIDTH*IDXW-1:0] free_idx,
  output logic [DISP_WIDTH-1:0]       disp_grant,
  output logic [DISP_WIDTH*IDXW-1:0]  alloc_idx,
  output logic [IDXW:0]               free_count,
  output logic                        rs_full
);

  localparam int CW = IDXW + 1;

  // Count of set bits. It is used on the next-state bitmap, so free_count
  // is always derived from the bitmap and cannot drift from it or wrap.
  function automatic logic [CW-1:0] popcount(input logic [RS_ENTRIES-1:0] vec);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int e = 0; e < RS_ENTRIES; e++) begin
      cnt = cnt + CW'(vec[e]);
    end
    return cnt;
  endfunction

  logic [RS_ENTRIES-1:0]      busy_r;
  logic [CW-1:0]              free_count_r;
  logic                       rs_full_r;

  logic                       grant_enable_s;
  logic [DISP_WIDTH-1:0]      grant_s;
  logic [DISP_WIDTH*IDXW-1:0] alloc_idx_s;
  logic [RS_ENTRIES-1:0]      alloc_mask_s;
  logic [RS_ENTRIES-1:0]      free_mask_s;
  logic [RS_ENTRIES-1:0]      busy_next_s;

  // Global grant qualifier: no grants during reset, flush or stall.
  assign grant_enable_s = rst && !flush && !disp_stall;

  // In-order grant: slot i needs every older slot valid and more than i free
  // entries, so a gap at slot j blocks all younger slots.
  always_comb begin
    logic chain_ok;
    grant_s  = '0;
    chain_ok = grant_enable_s;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      chain_ok = chain_ok && disp_valid[i] && (free_count_r > CW'(i));
      if (chain_ok) begin
        grant_s[i] = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Index selection: walk the free entries lowest first, handing one to each
  // granted slot in slot order. Taken entries are removed from the
  // candidate set so indices within a cycle are distinct.
  always_comb begin
    logic [RS_ENTRIES-1:0] avail;
    logic [IDXW-1:0]       sel;
    logic                  found;
    alloc_idx_s  = '0;
    alloc_mask_s = '0;
    avail        = ~busy_r;
    sel          = '0;
    found        = 1'b0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      sel   = '0;
      found = 1'b0;
      for (int e = 0; e < RS_ENTRIES; e++) begin
        if (!found && avail[e]) begin
          sel   = IDXW'(e);
          found = 1'b1;
        end else begin
          found = found;
        end
      end
      if (grant_s[i] && found) begin
        alloc_idx_s[i*IDXW +: IDXW] = sel;
        alloc_mask_s[sel]           = 1'b1;
        avail[sel]                  = 1'b0;
      end else begin
        alloc_idx_s[i*IDXW +: IDXW] = {IDXW{1'b0}};
      end
    end
  end

  // Release mask: OR of the one-hot release indices, so a duplicate index
  // on two ports clears the entry once. Releasing a free entry is a no-op.
  always_comb begin
    free_mask_s = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (free_valid[k]) begin
        free_mask_s[free_idx[k*IDXW +: IDXW]] = 1'b1;
      end else begin
        free_mask_s = free_mask_s;
      end
    end
  end

  // Next bitmap for the normal path. Newly allocated entries come only from
  // entries that were free, so they never overlap a release of a busy entry.
  assign busy_next_s = (busy_r & ~free_mask_s) | alloc_mask_s;

  // State update with priority reset > flush > normal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_r       <= '0;
      free_count_r <= CW'(RS_ENTRIES);
      rs_full_r    <= 1'b0;
    end else if (flush) begin
      busy_r       <= '0;
      free_count_r <= CW'(RS_ENTRIES);
      rs_full_r    <= 1'b0;
    end else begin
      busy_r       <= busy_next_s;
      free_count_r <= popcount(~busy_next_s);
      rs_full_r    <= (popcount(~busy_next_s) == {CW{1'b0}});
    end
  end

  assign disp_grant = grant_s;
  assign alloc_idx  = alloc_idx_s;
  assign free_count = free_count_r;
  assign rs_full    = rs_full_r;

endmodule

// File: tb/tb_rs_alloc_scheduler.sv
// Directed testbench for rs_alloc_scheduler (DISP_WIDTH=2, ISSUE_WIDTH=2,
// RS_ENTRIES=16). Inputs change 1 time unit after a rising edge;
// combinational outputs are checked 1 unit later and registered outputs
// just after the following rising edge.

module tb_rs_alloc_scheduler;

  localparam int DW = 2;
  localparam int IW = 2;
  localparam int N  = 16;
  localparam int XW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   disp_valid;
  logic            disp_stall;
  logic            flush;
  logic [IW-1:0]   free_valid;
  logic [IW*XW-1:0] free_idx;
  logic [DW-1:0]   disp_grant;
  logic [DW*XW-1:0] alloc_idx;
  logic [XW:0]     free_count;
  logic            rs_full;

  int n_chk  = 0;
  int n_pass = 0;
  int spurious_frees = 0;
  logic [N-1:0] shadow_busy = '0;

  wire [XW-1:0] a0 = alloc_idx[XW-1:0];
  wire [XW-1:0] a1 = alloc_idx[2*XW-1:XW];

  always #5 clk = ~clk;

  rs_alloc_scheduler #(
    .DISP_WIDTH (DW),
    .ISSUE_WIDTH(IW),
    .RS_ENTRIES (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_valid(disp_valid),
    .disp_stall(disp_stall),
    .flush     (flush),
    .free_valid(free_valid),
    .free_idx  (free_idx),
    .disp_grant(disp_grant),
    .alloc_idx (alloc_idx),
    .free_count(free_count),
    .rs_full   (rs_full)
  );

  // Protocol monitor: shadows the busy set from observed grants/releases
  // and counts releases of entries that are not busy.
  always @(posedge clk) begin
    logic [N-1:0] fm;
    logic [N-1:0] am;
    fm = '0;
    am = '0;
    if (!rst || flush) begin
      shadow_busy = '0;
    end else begin
      for (int k = 0; k < IW; k++) begin
        if (free_valid[k]) begin
          if (!shadow_busy[free_idx[k*XW +: XW]]) spurious_frees++;
          fm[free_idx[k*XW +: XW]] = 1'b1;
        end
      end
      for (int i = 0; i < DW; i++) begin
        if (disp_grant[i]) am[alloc_idx[i*XW +: XW]] = 1'b1;
      end
      shadow_busy = (shadow_busy & ~fm) | am;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_free(input logic [1:0] v, input logic [XW-1:0] i0, input logic [XW-1:0] i1);
    free_valid = v;
    free_idx   = {i1, i0};
  endtask

  initial begin
    rst        = 1'b0;
    disp_valid = 2'b11;
    disp_stall = 1'b0;
    flush      = 1'b0;
    set_free(2'b00, 4'd0, 4'd0);

    // Reset: no grants even with valid heads.
    cyc();
    #1;
    check("rst_grant", 32'(disp_grant), 32'd0);
    check("rst_alloc", 32'(alloc_idx), 32'd0);
    cyc();
    check("rst_free_count", 32'(free_count), 32'd16);
    check("rst_full", 32'(rs_full), 32'd0);
    rst = 1'b1;

    // Fill: pairs (0,1) .. (14,15).
    for (int c = 0; c < 8; c++) begin
      #1;
      check("fill_grant", 32'(disp_grant), 32'd3);
      check("fill_a0", 32'(a0), 32'(2 * c));
      check("fill_a1", 32'(a1), 32'(2 * c + 1));
      cyc();
      check("fill_free_count", 32'(free_count), 32'(16 - 2 * (c + 1)));
    end
    check("fill_full", 32'(rs_full), 32'd1);
    #1;
    check("full_grant", 32'(disp_grant), 32'd0);

    // Free 5 and 9 while full: same-cycle release is not allocatable.
    set_free(2'b11, 4'd5, 4'd9);
    #1;
    check("free_same_cycle_grant", 32'(disp_grant), 32'd0);
    cyc();
    check("free2_count", 32'(free_count), 32'd2);
    check("free2_full", 32'(rs_full), 32'd0);
    set_free(2'b00, 4'd0, 4'd0);
    #1;
    check("reuse_grant", 32'(disp_grant), 32'd3);
    check("reuse_a0", 32'(a0), 32'd5);
    check("reuse_a1", 32'(a1), 32'd9);
    cyc();
    check("reuse_count", 32'(free_count), 32'd0);
    check("reuse_full", 32'(rs_full), 32'd1);

    // Duplicate release of busy entry 3 counts once.
    disp_valid = 2'b00;
    set_free(2'b11, 4'd3, 4'd3);
    cyc();
    check("dup_free_count", 32'(free_count), 32'd1);
    set_free(2'b01, 4'd7, 4'd0);
    cyc();
    check("free7_count", 32'(free_count), 32'd2);
    // Spurious release of already-free entry 7.
    set_free(2'b01, 4'd7, 4'd0);
    cyc();
    check("spurious_free_count", 32'(free_count), 32'd2);
    check("spurious_flagged", 32'(spurious_frees), 32'd1);
    set_free(2'b00, 4'd0, 4'd0);

    // Partial capacity: free set {3,7}.
    disp_valid = 2'b01;
    #1;
    check("one_grant", 32'(disp_grant), 32'd1);
    check("one_a0", 32'(a0), 32'd3);
    cyc();
    check("one_count", 32'(free_count), 32'd1);
    disp_valid = 2'b11;
    #1;
    check("partial_grant", 32'(disp_grant), 32'd1);
    check("partial_a0", 32'(a0), 32'd7);
    check("partial_a1_zero", 32'(a1), 32'd0);
    cyc();
    check("partial_count", 32'(free_count), 32'd0);
    check("partial_full", 32'(rs_full), 32'd1);

    // Flush from full, with releases that must be ignored.
    flush = 1'b1;
    set_free(2'b11, 4'd0, 4'd1);
    #1;
    check("flush_full_grant", 32'(disp_grant), 32'd0);
    cyc();
    check("flush_full_count", 32'(free_count), 32'd16);
    check("flush_full_full", 32'(rs_full), 32'd0);
    flush = 1'b0;
    set_free(2'b00, 4'd0, 4'd0);

    // Half fill.
    for (int c = 0; c < 4; c++) begin
      #1;
      check("half_a0", 32'(a0), 32'(2 * c));
      cyc();
    end
    check("half_count", 32'(free_count), 32'd8);

    // Stall blocks grants and keeps state.
    disp_stall = 1'b1;
    #1;
    check("stall_grant", 32'(disp_grant), 32'd0);
    cyc();
    check("stall_count", 32'(free_count), 32'd8);
    disp_stall = 1'b0;

    // Flush from half-full.
    flush = 1'b1;
    #1;
    check("flush_half_grant", 32'(disp_grant), 32'd0);
    cyc();
    check("flush_half_count", 32'(free_count), 32'd16);
    flush = 1'b0;

    // In-order gap: slot 1 must not bypass slot 0.
    disp_valid = 2'b10;
    #1;
    check("gap_grant", 32'(disp_grant), 32'd0);
    check("gap_alloc", 32'(alloc_idx), 32'd0);
    cyc();
    check("gap_count", 32'(free_count), 32'd16);

    // Reset mid-fill.
    disp_valid = 2'b11;
    cyc();
    #1;
    check("midfill_a0", 32'(a0), 32'd2);
    cyc();
    check("midfill_count", 32'(free_count), 32'd12);
    rst = 1'b0;
    #1;
    check("midrst_grant", 32'(disp_grant), 32'd0);
    check("midrst_alloc", 32'(alloc_idx), 32'd0);
    cyc();
    check("midrst_count", 32'(free_count), 32'd16);
    check("midrst_full", 32'(rs_full), 32'd0);
    rst = 1'b1;
    #1;
    check("post_rst_grant", 32'(disp_grant), 32'd3);
    check("post_rst_a1", 32'(a1), 32'd1);
    cyc();
    check("post_rst_count", 32'(free_count), 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rs_alloc_scheduler.md
# rs_alloc_scheduler

Reservation-station entry allocator and dispatch scheduler for the backend. Each cycle it examines the heads of the DISP_WIDTH dispatch queues and grants them in program order into free wakeup/select entries. It returns the allocated entry index for each granted slot and drives the dispatch-queue read enables. It reclaims entries when the issue stage reports them freed, and on pipeline flush.

## Interface
Parameters:
- DISP_WIDTH, 2, dispatch slots per cycle; slot 0 is oldest.
- ISSUE_WIDTH, 2, entry-free ports per cycle.
- RS_ENTRIES, 16, number of reservation-station entries; power of two, ≥ DISP_WIDTH.
- IDXW, $clog2(RS_ENTRIES), entry index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- disp_valid  in  DISP_WIDTH  bit i: dispatch queue i head holds a valid uop.
- disp_stall  in  1  backend stall; no grants while high.
- flush  in  1  pipeline flush; frees all entries.
- free_valid  in  ISSUE_WIDTH  bit k: entry free_idx[k] is released by issue.
- free_idx  in  ISSUE_WIDTH*IDXW  packed indices of released entries.
- disp_grant  out  DISP_WIDTH  bit i: slot i dispatched this cycle; wired to queue i r_en.
- alloc_idx  out  DISP_WIDTH*IDXW  packed entry index for each granted slot; zero when not granted.
- free_count  out  IDXW+1  registered count of free entries.
- rs_full  out  1  registered; high when free_count == 0.

## Operation
- State: busy bitmap [RS_ENTRIES] and free_count register; free_count always equals popcount(~busy).
- Grant rule, all combinational from the registered bitmap:
  - disp_grant[i] = !rst_active && !flush && !disp_stall && disp_valid[0..i] all 1 && free_count > i.
  - Grants are in order: no gaps. If slot j is not granted, no slot above j is granted.
- Index selection:
  - Granted slot 0 receives the lowest-numbered free entry.
  - Granted slot 1 receives the next-lowest free entry, and so on.
  - Indices within a cycle are distinct.
- Next-state update, with priority reset > flush > normal:
  - Reset: busy = 0; free_count = RS_ENTRIES.
  - Flush: busy = 0; free_count = RS_ENTRIES. Same-cycle frees and grants are ignored, and grants are already suppressed.
  - Normal: busy' = (busy & ~freemask) | allocmask.
    - freemask is the OR of one-hot(free_idx[k]) over all k with free_valid[k] set.
    - free_count' = popcount(~busy').
- Free edge cases:
  - Duplicate free_idx on two ports counts once.
  - Freeing an entry that is not busy has no effect; the bench flags it with an assertion.
- Only entries free at the start of the cycle are allocatable. An entry freed in cycle N becomes allocatable in cycle N+1. An allocated entry can never also be freed in the same cycle.
- Width rule: free_count ranges 0..RS_ENTRIES and must not wrap.

## Timing
- Grant latency: 0 cycles. disp_grant/alloc_idx are combinational from disp_valid, disp_stall, flush and registered state.
- Allocation becomes visible in busy/free_count/rs_full 1 cycle after the grant.
- Free becomes visible 1 cycle after free_valid.
- Flush: every entry is free on the cycle after flush is asserted.
- Reset values (rst low at an edge):
  - busy = 0, free_count = RS_ENTRIES, rs_full = 0.
  - disp_grant = 0 and alloc_idx = 0 while rst is low.
- Reset mid-operation discards all allocations. No grant is issued in any cycle where rst is sampled low.
- Handshake: a queue pops only on disp_grant[i]. disp_valid must stay stable until granted; the block never grants on a low valid.

## Test plan
- Reset then fill (RS_ENTRIES=16, DISP_WIDTH=2): hold disp_valid=2'b11 for 8 cycles.
  - Grants are 11 every cycle, with alloc_idx pairs (0,1), (2,3) … (14,15).
  - free_count steps 16→0 and rs_full=1 after cycle 8.
  - Cycle 9 grants 00.
- Partial capacity: 15 entries busy, disp_valid=11 → disp_grant=01, alloc_idx[0]=the single free index; next cycle rs_full=1.
- In-order gap: disp_valid=2'b10 with 16 free → disp_grant=00; slot 1 must not bypass slot 0.
- Free/reuse: full RS.
  - free_valid=11 with free_idx=(5,9) → next cycle free_count=2.
  - disp_valid=11 then → alloc_idx=(5,9).
  - The same-cycle free/alloc of entry 5 while it is still busy yields no grant.
- Duplicate/spurious free: free_idx=(3,3) on busy entry 3 raises free_count by 1. Freeing already-free entry 7 changes nothing and fires the assertion.
- Flush/stall/reset priority:
  - Half-full RS with flush=1 and disp_valid=11 → grant=00, free_count=16 next cycle.
  - disp_stall=1 → grant=00.
  - rst low mid-fill → grant=00, free_count=16 next cycle.
